// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes codec SCLK/LRCLK/data into CLK, deserializes MSB-first
// left/right words and presents complete stereo frames on a valid/ready interface.
`timescale 1ns/1ps
module i2s_rx #(
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic                    SCLK,
  input  logic                    LRCLK,
  input  logic                    I2S_Din,
  output logic [SAMPLE_WIDTH-1:0] LEFT_DATA,
  output logic [SAMPLE_WIDTH-1:0] RIGHT_DATA,
  output logic                    FRAME_VALID,
  input  logic                    FRAME_READY,
  output logic                    OVERRUN,
  output logic                    SYNC_ERR
);

  localparam int unsigned CW = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SEEK, LEFT, RIGHT} state_e;

  state_e                  state_q;
  logic [2:0]              sclk_q;
  logic [1:0]              lr_sync_q;
  logic [1:0]              din_sync_q;
  logic                    lr_prev_q;
  logic [SAMPLE_WIDTH-1:0] shift_q;
  logic [CW-1:0]           bitcnt_q;
  logic [SAMPLE_WIDTH-1:0] left_stage_q;
  logic [SAMPLE_WIDTH-1:0] right_stage_q;
  logic                    left_done_q;
  logic                    frame_done_q;
  logic [SAMPLE_WIDTH-1:0] left_data_q;
  logic [SAMPLE_WIDTH-1:0] right_data_q;
  logic                    valid_q;
  logic                    overrun_q;
  logic                    sync_err_q;

  logic                    rise;
  logic                    lr;
  logic                    din;
  logic                    boundary;
  logic                    short_slot;
  logic                    last_bit;
  logic [SAMPLE_WIDTH-1:0] word;

  always_comb begin
    rise       = sclk_q[1] & ~sclk_q[2];
    lr         = lr_sync_q[1];
    din        = din_sync_q[1];
    boundary   = rise && (lr != lr_prev_q);
    short_slot = (bitcnt_q < CW'(SAMPLE_WIDTH));
    last_bit   = (bitcnt_q == CW'(SAMPLE_WIDTH - 1));
    word       = {shift_q[SAMPLE_WIDTH-2:0], din};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sclk_q     <= '0;
      lr_sync_q  <= '0;
      din_sync_q <= '0;
    end else begin
      sclk_q     <= {sclk_q[1:0], SCLK};
      lr_sync_q  <= {lr_sync_q[0], LRCLK};
      din_sync_q <= {din_sync_q[0], I2S_Din};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      lr_prev_q     <= 1'b0;
      shift_q       <= '0;
      bitcnt_q      <= '0;
      left_stage_q  <= '0;
      right_stage_q <= '0;
      left_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      left_data_q   <= '0;
      right_data_q  <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (rise) lr_prev_q <= lr;

      unique case (state_q)
        IDLE: begin
          shift_q     <= '0;
          bitcnt_q    <= '0;
          left_done_q <= 1'b0;
          overrun_q   <= 1'b0;
          sync_err_q  <= 1'b0;
          if (EN) state_q <= SEEK;
        end
        SEEK: begin
          if (boundary && !lr) begin
            state_q  <= LEFT;
            shift_q  <= '0;
            bitcnt_q <= '0;
          end
        end
        LEFT, RIGHT: begin
          if (boundary) begin
            // The new lr picks the slot; the bit sampled here belongs to the old slot.
            shift_q  <= '0;
            bitcnt_q <= '0;
            state_q  <= lr ? RIGHT : LEFT;
            if (short_slot) begin
              sync_err_q  <= 1'b1;
              left_done_q <= 1'b0;
            end
          end else if (rise && short_slot) begin
            shift_q  <= word;
            bitcnt_q <= bitcnt_q + CW'(1);
            if (last_bit) begin
              if (state_q == LEFT) begin
                left_stage_q <= word;
                left_done_q  <= 1'b1;
              end else begin
                right_stage_q <= word;
                frame_done_q  <= left_done_q;
                left_done_q   <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (!EN) state_q <= IDLE;

      if (frame_done_q && (!valid_q || FRAME_READY)) begin
        left_data_q  <= left_stage_q;
        right_data_q <= right_stage_q;
        valid_q      <= 1'b1;
      end else if (frame_done_q) begin
        overrun_q <= 1'b1;
      end else if (FRAME_READY && valid_q) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign LEFT_DATA   = left_data_q;
  assign RIGHT_DATA  = right_data_q;
  assign FRAME_VALID = valid_q;
  assign OVERRUN     = overrun_q;
  assign SYNC_ERR    = sync_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: bit-bangs I2S slots and checks delivered frames against a slot-level model.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int unsigned W = 16;

  logic         CLK = 1'b0;
  logic         RESET, EN, SCLK, LRCLK, I2S_Din, FRAME_READY;
  logic [W-1:0] LEFT_DATA, RIGHT_DATA;
  logic         FRAME_VALID, OVERRUN, SYNC_ERR;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         lr;
    int unsigned  nbits;
    logic [W-1:0] w;
  } slot_t;

  slot_t          slots[$];
  logic [2*W-1:0] got[$];
  logic [2*W-1:0] exp_q[$];
  logic           exp_serr;

  i2s_rx #(.SAMPLE_WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .SCLK(SCLK), .LRCLK(LRCLK), .I2S_Din(I2S_Din),
    .LEFT_DATA(LEFT_DATA), .RIGHT_DATA(RIGHT_DATA), .FRAME_VALID(FRAME_VALID),
    .FRAME_READY(FRAME_READY), .OVERRUN(OVERRUN), .SYNC_ERR(SYNC_ERR)
  );

  always #10 CLK = ~CLK;

  // Record every accepted frame, sampled just before the edge that performs the handshake.
  always @(negedge CLK) begin
    #5;
    if (FRAME_VALID === 1'b1 && FRAME_READY === 1'b1) got.push_back({LEFT_DATA, RIGHT_DATA});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sfall(input logic lr, input logic d);
    @(negedge CLK); SCLK = 1'b0; LRCLK = lr; I2S_Din = d;
    repeat (7) @(negedge CLK);
  endtask

  task automatic srise();
    @(negedge CLK); SCLK = 1'b1;
    repeat (7) @(negedge CLK);
  endtask

  task automatic slot_head(input logic lr, input logic [W-1:0] w, input int unsigned nbits);
    sfall(lr, 1'($urandom)); srise();
    for (int i = 0; i < int'(nbits); i++) begin
      sfall(lr, w[W-1-i]); srise();
    end
  endtask

  task automatic slot_tail(input logic lr, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      sfall(lr, 1'($urandom)); srise();
    end
  endtask

  task automatic full_slot(input logic lr, input logic [W-1:0] w);
    slot_head(lr, w, W);
    slot_tail(lr, 15);
    slots.push_back('{lr, W, w});
  endtask

  // Slot-level reference: frames start at the first right->left change; a frame is a
  // complete left slot followed by a complete right slot; any short slot that is closed
  // by a following slot raises the sync error.
  task automatic build_expect(input logic prev0);
    logic         prev     = prev0;
    logic         seeking  = 1'b1;
    logic         left_ok  = 1'b0;
    logic         complete;
    logic [W-1:0] lw       = '0;
    exp_q.delete();
    exp_serr = 1'b0;
    foreach (slots[k]) begin
      if (slots[k].lr != prev) begin
        if (seeking && !slots[k].lr) seeking = 1'b0;
        if (!seeking) begin
          complete = (slots[k].nbits >= W);
          if (!complete && (k + 1 < slots.size())) exp_serr = 1'b1;
          if (!slots[k].lr) begin
            left_ok = complete;
            lw      = slots[k].w;
          end else begin
            if (complete && left_ok) exp_q.push_back({lw, slots[k].w});
            left_ok = 1'b0;
          end
        end
      end
      prev = slots[k].lr;
    end
  endtask

  task automatic enable_cycle();
    @(negedge CLK); EN = 1'b0;
    repeat (3) @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; EN = 1'b0; SCLK = 1'b0; LRCLK = 1'b0; I2S_Din = 1'b0; FRAME_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (LEFT_DATA !== '0) begin n_err++; $display("FAIL reset_left: got %h want 0", LEFT_DATA); end
    n_cmp++; if (RIGHT_DATA !== '0) begin n_err++; $display("FAIL reset_right: got %h want 0", RIGHT_DATA); end
    n_cmp++; if (FRAME_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", FRAME_VALID); end
    n_cmp++; if (OVERRUN !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
    n_cmp++; if (SYNC_ERR !== 1'b0) begin n_err++; $display("FAIL reset_syncerr: got %b want 0", SYNC_ERR); end
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] r = 16'h1234;
    slots.delete(); got.delete();
    FRAME_READY = 1'b1; EN = 1'b1;
    full_slot(1'b1, W'($urandom));
    full_slot(1'b0, 16'hA5C3);
    slot_head(1'b1, r, W - 1);
    sfall(1'b1, r[0]);
    @(negedge CLK); SCLK = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (FRAME_VALID !== 1'b0) begin n_err++; $display("FAIL latency_early: valid %b want 0 at 3 clk", FRAME_VALID); end
    @(posedge CLK);
    #1;
    n_cmp++; if (FRAME_VALID !== 1'b1) begin n_err++; $display("FAIL latency_valid: valid %b want 1 at 4 clk", FRAME_VALID); end
    n_cmp++; if (LEFT_DATA !== 16'hA5C3) begin n_err++; $display("FAIL basic_left: got %h want a5c3", LEFT_DATA); end
    n_cmp++; if (RIGHT_DATA !== 16'h1234) begin n_err++; $display("FAIL basic_right: got %h want 1234", RIGHT_DATA); end
    repeat (5) @(negedge CLK);
    slot_tail(1'b1, 15);
    slots.push_back('{1'b1, W, r});
    build_expect(1'b0);
    n_cmp++; if (OVERRUN !== 1'b0) begin n_err++; $display("FAIL basic_overrun: got %b want 0", OVERRUN); end
    n_cmp++; if (SYNC_ERR !== 1'b0) begin n_err++; $display("FAIL basic_syncerr: got %b want 0", SYNC_ERR); end
    n_cmp++; if (got.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d frames want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      n_cmp++; if (got[k] !== exp_q[k]) begin n_err++; $display("FAIL basic_frame%0d: got %h want %h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_en_mid_right();
    slots.delete();
    @(negedge CLK); EN = 1'b0; FRAME_READY = 1'b1;
    slot_head(1'b0, W'($urandom), W);
    slot_tail(1'b0, 15);
    slot_head(1'b1, W'($urandom), 9);
    @(negedge CLK); EN = 1'b1;
    got.delete();
    slot_tail(1'b1, 22);
    slots.push_back('{1'b1, 0, '0});
    full_slot(1'b0, W'($urandom));
    full_slot(1'b1, W'($urandom));
    build_expect(1'b1);
    n_cmp++; if (got.size() != exp_q.size()) begin n_err++; $display("FAIL enmid_count: got %0d frames want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      n_cmp++; if (got[k] !== exp_q[k]) begin n_err++; $display("FAIL enmid_frame%0d: got %h want %h", k, got[k], exp_q[k]); end
    end
    n_cmp++; if (SYNC_ERR !== 1'b0) begin n_err++; $display("FAIL enmid_syncerr: got %b want 0", SYNC_ERR); end
  endtask

  task automatic test_overrun();
    logic [W-1:0] fl[4];
    logic [W-1:0] fr[4];
    for (int i = 0; i < 4; i++) begin fl[i] = W'($urandom); fr[i] = W'($urandom); end
    FRAME_READY = 1'b0;
    enable_cycle();
    full_slot(1'b0, fl[0]); full_slot(1'b1, fr[0]);
    n_cmp++; if (FRAME_VALID !== 1'b1) begin n_err++; $display("FAIL ovr_valid1: got %b want 1", FRAME_VALID); end
    n_cmp++; if (OVERRUN !== 1'b0) begin n_err++; $display("FAIL ovr_flag1: got %b want 0", OVERRUN); end
    full_slot(1'b0, fl[1]); full_slot(1'b1, fr[1]);
    n_cmp++; if (OVERRUN !== 1'b1) begin n_err++; $display("FAIL ovr_flag2: got %b want 1", OVERRUN); end
    full_slot(1'b0, fl[2]); full_slot(1'b1, fr[2]);
    n_cmp++; if (LEFT_DATA !== fl[0]) begin n_err++; $display("FAIL ovr_hold_left: got %h want %h", LEFT_DATA, fl[0]); end
    n_cmp++; if (RIGHT_DATA !== fr[0]) begin n_err++; $display("FAIL ovr_hold_right: got %h want %h", RIGHT_DATA, fr[0]); end
    n_cmp++; if (FRAME_VALID !== 1'b1) begin n_err++; $display("FAIL ovr_hold_valid: got %b want 1", FRAME_VALID); end
    FRAME_READY = 1'b1;
    @(negedge CLK); FRAME_READY = 1'b0;
    n_cmp++; if (FRAME_VALID !== 1'b0) begin n_err++; $display("FAIL ovr_consume: valid %b want 0", FRAME_VALID); end
    full_slot(1'b0, fl[3]); full_slot(1'b1, fr[3]);
    n_cmp++; if (LEFT_DATA !== fl[3] || RIGHT_DATA !== fr[3]) begin
      n_err++; $display("FAIL ovr_frame4: got %h/%h want %h/%h", LEFT_DATA, RIGHT_DATA, fl[3], fr[3]);
    end
    n_cmp++; if (FRAME_VALID !== 1'b1) begin n_err++; $display("FAIL ovr_valid4: got %b want 1", FRAME_VALID); end
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (OVERRUN !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", OVERRUN); end
    n_cmp++; if (LEFT_DATA !== fl[3]) begin n_err++; $display("FAIL ovr_idle_hold: got %h want %h", LEFT_DATA, fl[3]); end
    FRAME_READY = 1'b1;
    @(negedge CLK); FRAME_READY = 1'b0;
    EN = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a = W'($urandom);
    logic [W-1:0] b = W'($urandom);
    logic [W-1:0] c = ~a;
    logic [W-1:0] d = ~b;
    FRAME_READY = 1'b0;
    enable_cycle();
    full_slot(1'b0, a); full_slot(1'b1, b);
    n_cmp++; if (FRAME_VALID !== 1'b1 || LEFT_DATA !== a) begin
      n_err++; $display("FAIL b2b_first: valid %b left %h want 1 %h", FRAME_VALID, LEFT_DATA, a);
    end
    full_slot(1'b0, c);
    slot_head(1'b1, d, W - 1);
    sfall(1'b1, d[0]);
    @(negedge CLK); SCLK = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK); FRAME_READY = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++; if (FRAME_VALID !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", FRAME_VALID); end
    n_cmp++; if (LEFT_DATA !== c || RIGHT_DATA !== d) begin
      n_err++; $display("FAIL b2b_data: got %h/%h want %h/%h", LEFT_DATA, RIGHT_DATA, c, d);
    end
    n_cmp++; if (OVERRUN !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", OVERRUN); end
    @(negedge CLK); FRAME_READY = 1'b0;
    repeat (5) @(negedge CLK);
    slot_tail(1'b1, 15);
    n_cmp++; if (FRAME_VALID !== 1'b1 || LEFT_DATA !== c) begin
      n_err++; $display("FAIL b2b_stable: valid %b left %h want 1 %h", FRAME_VALID, LEFT_DATA, c);
    end
    FRAME_READY = 1'b1;
    @(negedge CLK); FRAME_READY = 1'b0;
  endtask

  task automatic test_sync_err();
    logic [W-1:0] x = W'($urandom);
    FRAME_READY = 1'b1;
    enable_cycle();
    slots.delete(); got.delete();
    full_slot(1'b0, W'($urandom)); full_slot(1'b1, W'($urandom));
    slot_head(1'b0, x, 10);
    slots.push_back('{1'b0, 10, x});
    full_slot(1'b1, W'($urandom));
    full_slot(1'b0, W'($urandom)); full_slot(1'b1, W'($urandom));
    build_expect(1'b1);
    n_cmp++; if (SYNC_ERR !== exp_serr) begin n_err++; $display("FAIL serr_flag: got %b want %b", SYNC_ERR, exp_serr); end
    n_cmp++; if (got.size() != exp_q.size()) begin n_err++; $display("FAIL serr_count: got %0d frames want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      n_cmp++; if (got[k] !== exp_q[k]) begin n_err++; $display("FAIL serr_frame%0d: got %h want %h", k, got[k], exp_q[k]); end
    end
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (SYNC_ERR !== 1'b0) begin n_err++; $display("FAIL serr_clear: got %b want 0", SYNC_ERR); end
    EN = 1'b1;
  endtask

  task automatic test_reset_mid();
    FRAME_READY = 1'b0;
    enable_cycle();
    full_slot(1'b0, W'($urandom) | 16'h0001); full_slot(1'b1, W'($urandom));
    full_slot(1'b0, W'($urandom));
    slot_head(1'b1, W'($urandom), 8);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++; if (LEFT_DATA !== '0 || RIGHT_DATA !== '0) begin
      n_err++; $display("FAIL rstmid_data: got %h/%h want 0/0", LEFT_DATA, RIGHT_DATA);
    end
    n_cmp++; if (FRAME_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", FRAME_VALID); end
    @(negedge CLK); RESET = 1'b0; FRAME_READY = 1'b1;
    slots.delete(); got.delete();
    slot_tail(1'b1, 23);
    slots.push_back('{1'b1, 0, '0});
    full_slot(1'b0, W'($urandom)); full_slot(1'b1, W'($urandom));
    build_expect(1'b0);
    n_cmp++; if (got.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_count: got %0d frames want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      n_cmp++; if (got[k] !== exp_q[k]) begin n_err++; $display("FAIL rstmid_frame%0d: got %h want %h", k, got[k], exp_q[k]); end
    end
    n_cmp++; if (OVERRUN !== 1'b0 || SYNC_ERR !== 1'b0) begin
      n_err++; $display("FAIL rstmid_flags: overrun %b syncerr %b want 0 0", OVERRUN, SYNC_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_en_mid_right();
    test_overrun();
    test_back_to_back();
    test_sync_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
